// File: rtl/fetch_stage_if.sv
// IF-stage bus bundle: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = the surrounding pipeline and memory.
interface fetch_stage_if #(
  parameter int WORD_LEN = 32
);
  logic                stall;
  logic                redirect_valid;
  logic [WORD_LEN-1:0] redirect_pc;
  logic [WORD_LEN-1:0] imem_addr;
  logic [WORD_LEN-1:0] imem_instr;
  logic [WORD_LEN-1:0] ifid_pc;
  logic [WORD_LEN-1:0] ifid_pc_plus4;
  logic [WORD_LEN-1:0] ifid_instr;
  logic                ifid_valid;
  logic                halted;
  logic                fetch_err;
  logic [31:0]         fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid,
           halted, fetch_err, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid,
           halted, fetch_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads async instruction memory, fills IF/ID.
// Handles boot cycle, stalls, EX redirects with flush, zero-word halt and sticky redirect errors.
module fetch_stage #(
  parameter int                  WORD_LEN       = 32,
  parameter int                  INSTR_MEM_SIZE = 1024,
  parameter logic [WORD_LEN-1:0] RESET_PC       = '0,
  parameter logic [WORD_LEN-1:0] NOP_INSTR      = WORD_LEN'(32'h00000013)
) (
  input  logic          clk,
  input  logic          nReset,
  fetch_stage_if.master bus
);

  localparam logic [WORD_LEN-1:0] MEM_SIZE_W = WORD_LEN'(INSTR_MEM_SIZE);
  localparam logic [WORD_LEN-1:0] ADDR_MASK  = MEM_SIZE_W - WORD_LEN'(1);

  typedef enum logic [1:0] {BOOT, RUN, HALT, ERR} state_t;

  state_t              r_state;
  logic [WORD_LEN-1:0] r_pc;
  logic [WORD_LEN-1:0] r_ifid_pc;
  logic [WORD_LEN-1:0] r_ifid_pc_plus4;
  logic [WORD_LEN-1:0] r_ifid_instr;
  logic                r_ifid_valid;
  logic                r_halted;
  logic                r_fetch_err;
  logic [31:0]         r_fetch_count;

  logic [WORD_LEN-1:0] w_pc_plus4;
  logic                w_redir_ok;
  logic                w_zero_word;

  // PC stays inside the memory window, so the increment wraps by masking.
  assign w_pc_plus4  = (r_pc + WORD_LEN'(4)) & ADDR_MASK;
  assign w_redir_ok  = (bus.redirect_pc[1:0] == 2'b00) && (bus.redirect_pc < MEM_SIZE_W);
  assign w_zero_word = (bus.imem_instr == '0);

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state         <= BOOT;
      r_pc            <= RESET_PC;
      r_ifid_pc       <= '0;
      r_ifid_pc_plus4 <= '0;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_valid    <= 1'b0;
      r_halted        <= 1'b0;
      r_fetch_err     <= 1'b0;
      r_fetch_count   <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;

        RUN: begin
          if (bus.redirect_valid) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            if (w_redir_ok) begin
              r_pc <= bus.redirect_pc;
            end else begin
              r_state     <= ERR;
              r_fetch_err <= 1'b1;
            end
          end else if (!bus.stall) begin
            if (!w_zero_word) begin
              r_ifid_pc       <= r_pc;
              r_ifid_pc_plus4 <= w_pc_plus4;
              r_ifid_instr    <= bus.imem_instr;
              r_ifid_valid    <= 1'b1;
              r_pc            <= w_pc_plus4;
              r_fetch_count   <= r_fetch_count + 32'd1;
            end else begin
              // End of program: park on the zero word until a redirect or reset.
              r_state      <= HALT;
              r_halted     <= 1'b1;
              r_ifid_instr <= NOP_INSTR;
              r_ifid_valid <= 1'b0;
            end
          end
        end

        HALT: begin
          // A redirect here means the halt was on a wrong path.
          if (bus.redirect_valid) begin
            r_halted <= 1'b0;
            if (w_redir_ok) begin
              r_pc    <= bus.redirect_pc;
              r_state <= RUN;
            end else begin
              r_state     <= ERR;
              r_fetch_err <= 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.imem_addr     = r_pc;
  assign bus.ifid_pc       = r_ifid_pc;
  assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.halted        = r_halted;
  assign bus.fetch_err     = r_fetch_err;
  assign bus.fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, then random traffic vs a behavioural model.
module tb_fetch_stage;
  localparam int          MS  = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic nReset = 1'b0;

  fetch_stage_if #(.WORD_LEN(32)) bus();
  fetch_stage #(.WORD_LEN(32), .INSTR_MEM_SIZE(MS)) dut (.clk(clk), .nReset(nReset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [MS];

  always_comb begin
    logic [9:0] a;
    a = bus.imem_addr[9:0];
    bus.imem_instr = {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_word(int unsigned a, logic [31:0] w);
    {mem[a], mem[a+1], mem[a+2], mem[a+3]} = w;
  endtask

  function automatic logic [31:0] word_at(int unsigned a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Behavioural model of the fetch stage, stepped once per clock edge.
  typedef enum {M_BOOT, M_RUN, M_HALT, M_ERR} mmode_t;
  mmode_t      m_mode = M_BOOT;
  int unsigned m_pc = 0;
  logic [31:0] m_ipc = 0, m_ip4 = 0, m_iinstr = NOP, m_cnt = 0;
  bit          m_iv = 0, m_halt = 0, m_err = 0;

  task automatic model_step(bit rst, bit st, bit rv, logic [31:0] rpc);
    bit legal;
    logic [31:0] w;
    legal = (rpc % 4 == 0) && (rpc < 32'(MS));
    if (rst) begin
      m_mode = M_BOOT; m_pc = 0; m_ipc = 0; m_ip4 = 0; m_iinstr = NOP;
      m_iv = 0; m_halt = 0; m_err = 0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN: begin
        if (rv) begin
          m_iinstr = NOP; m_iv = 0;
          if (legal) m_pc = rpc;
          else begin m_mode = M_ERR; m_err = 1; end
        end else if (!st) begin
          w = word_at(m_pc);
          if (w != 0) begin
            m_ipc = m_pc;
            m_pc = (m_pc + 4) % MS;
            m_ip4 = m_pc;
            m_iinstr = w; m_iv = 1; m_cnt = m_cnt + 1;
          end else begin
            m_mode = M_HALT; m_halt = 1; m_iinstr = NOP; m_iv = 0;
          end
        end
      end
      M_HALT: begin
        if (rv) begin
          m_halt = 0;
          if (legal) begin m_pc = rpc; m_mode = M_RUN; end
          else begin m_mode = M_ERR; m_err = 1; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk_model();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("ifid_pc", bus.ifid_pc, m_ipc);
    chk("ifid_pc_plus4", bus.ifid_pc_plus4, m_ip4);
    chk("ifid_instr", bus.ifid_instr, m_iinstr);
    chk("ifid_valid", 32'(bus.ifid_valid), 32'(m_iv));
    chk("halted", 32'(bus.halted), 32'(m_halt));
    chk("fetch_err", 32'(bus.fetch_err), 32'(m_err));
    chk("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic cycle(bit rst, bit st, bit rv, logic [31:0] rpc);
    nReset = !rst;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    @(posedge clk);
    model_step(rst, st, rv, rpc);
    #1;
    chk_model();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " imem_addr"}, bus.imem_addr, 32'h0);
    chk({tag, " ifid_pc"}, bus.ifid_pc, 32'h0);
    chk({tag, " ifid_pc_plus4"}, bus.ifid_pc_plus4, 32'h0);
    chk({tag, " ifid_instr"}, bus.ifid_instr, NOP);
    chk({tag, " ifid_valid"}, 32'(bus.ifid_valid), 32'h0);
    chk({tag, " halted"}, 32'(bus.halted), 32'h0);
    chk({tag, " fetch_err"}, 32'(bus.fetch_err), 32'h0);
    chk({tag, " fetch_count"}, bus.fetch_count, 32'h0);
  endtask

  typedef struct {
    bit          st;
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    bit          v;
    logic [31:0] ipc;
    logic [31:0] ip4;
    logic [31:0] instr;
    bit          h;
    bit          e;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [31:0] W0 = 32'h00100093, W4 = 32'h00200113, W8 = 32'h00300193;
  localparam logic [31:0] WC = 32'h00400213, W20 = 32'h00500293, W24 = 32'h00600313;
  localparam logic [31:0] W3FC = 32'h00700393;

  vec_t tbl [19];

  initial begin
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    for (int i = 0; i < MS; i++) mem[i] = 8'h00;
    set_word(0, W0); set_word(4, W4); set_word(8, W8); set_word(12, WC);
    set_word(16, 32'h0); set_word(32'h20, W20); set_word(32'h24, W24); set_word(32'h3FC, W3FC);

    //            st rv rpc     addr    v ipc     ip4     instr h e cnt
    tbl[0]  = '{0, 0, 0,      0,      0, 0,      0,      NOP,  0, 0, 0};
    tbl[1]  = '{0, 0, 0,      4,      1, 0,      4,      W0,   0, 0, 1};
    tbl[2]  = '{0, 0, 0,      8,      1, 4,      8,      W4,   0, 0, 2};
    tbl[3]  = '{1, 0, 0,      8,      1, 4,      8,      W4,   0, 0, 2};
    tbl[4]  = '{1, 0, 0,      8,      1, 4,      8,      W4,   0, 0, 2};
    tbl[5]  = '{1, 0, 0,      8,      1, 4,      8,      W4,   0, 0, 2};
    tbl[6]  = '{0, 0, 0,      12,     1, 8,      12,     W8,   0, 0, 3};
    tbl[7]  = '{0, 0, 0,      16,     1, 12,     16,     WC,   0, 0, 4};
    tbl[8]  = '{0, 0, 0,      16,     0, 12,     16,     NOP,  1, 0, 4};
    tbl[9]  = '{1, 0, 0,      16,     0, 12,     16,     NOP,  1, 0, 4};
    tbl[10] = '{0, 1, 4,      4,      0, 12,     16,     NOP,  0, 0, 4};
    tbl[11] = '{0, 0, 0,      8,      1, 4,      8,      W4,   0, 0, 5};
    tbl[12] = '{1, 1, 'h20,   'h20,   0, 4,      8,      NOP,  0, 0, 5};
    tbl[13] = '{0, 0, 0,      'h24,   1, 'h20,   'h24,   W20,  0, 0, 6};
    tbl[14] = '{0, 1, 'h3FC,  'h3FC,  0, 'h20,   'h24,   NOP,  0, 0, 6};
    tbl[15] = '{0, 0, 0,      0,      1, 'h3FC,  0,      W3FC, 0, 0, 7};
    tbl[16] = '{0, 1, 'h22,   0,      0, 'h3FC,  0,      NOP,  0, 1, 7};
    tbl[17] = '{0, 1, 4,      0,      0, 'h3FC,  0,      NOP,  0, 1, 7};
    tbl[18] = '{0, 0, 0,      0,      0, 'h3FC,  0,      NOP,  0, 1, 7};

    cycle(1, 0, 0, 0);
    chk_reset_vals("reset");

    for (int i = 0; i < 19; i++) begin
      cycle(0, tbl[i].st, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("vec%0d addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d valid", i), 32'(bus.ifid_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d ifid_pc", i), bus.ifid_pc, tbl[i].ipc);
      chk($sformatf("vec%0d pc_plus4", i), bus.ifid_pc_plus4, tbl[i].ip4);
      chk($sformatf("vec%0d instr", i), bus.ifid_instr, tbl[i].instr);
      chk($sformatf("vec%0d halted", i), 32'(bus.halted), 32'(tbl[i].h));
      chk($sformatf("vec%0d err", i), 32'(bus.fetch_err), 32'(tbl[i].e));
      chk($sformatf("vec%0d count", i), bus.fetch_count, tbl[i].cnt);
    end

    // Out-of-range redirect from RUN.
    cycle(1, 0, 0, 0);
    chk_reset_vals("err cleared by reset");
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h400);
    chk("oor err", 32'(bus.fetch_err), 32'h1);
    chk("oor pc held", bus.imem_addr, 32'h8);
    chk("oor valid", 32'(bus.ifid_valid), 32'h0);

    // Misaligned redirect while halted.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("halt reached", 32'(bus.halted), 32'h1);
    cycle(0, 0, 1, 32'h22);
    chk("halt->err err", 32'(bus.fetch_err), 32'h1);
    chk("halt->err halted", 32'(bus.halted), 32'h0);

    // Reset mid-run with a redirect pending.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 32'h40);
    chk_reset_vals("midrun reset");

    // Random traffic on a random program image.
    for (int i = 0; i < MS; i += 4)
      set_word(i, ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1));
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rst, st, rv;
      logic [31:0] rpc;
      int sel;
      rst = ($urandom_range(0, 149) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 15);
      if (sel < 14)       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (sel == 14) rpc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else                rpc = 32'(MS) + ($urandom & 32'h0000_FFFC);
      cycle(rst, st, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the byte address into the asynchronous-read, byte-addressed instruction memory. Memory word order: byte at addr is bits [31:24].
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage branch/jump redirects with IF/ID flush, a post-reset boot cycle, and end-of-program (all-zero word) halt.

Parameters:
WORD_LEN, 32, datapath/PC width
INSTR_MEM_SIZE, 1024, instruction memory size in bytes; power of 2
RESET_PC, 0, PC after reset; word aligned
NOP_INSTR, 32'h00000013, bubble inserted into IF/ID (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
nReset  in  1  reset; synchronous, active-low
stall  in  1  hazard unit: hold PC and IF/ID
redirect_valid  in  1  EX resolved taken branch/jump this cycle
redirect_pc  in  WORD_LEN  redirect target byte address
imem_addr  out  WORD_LEN  byte address to instruction memory
imem_instr  in  WORD_LEN  instruction word at imem_addr, same cycle
ifid_pc  out  WORD_LEN  PC of instruction in IF/ID
ifid_pc_plus4  out  WORD_LEN  ifid_pc+4, modulo INSTR_MEM_SIZE
ifid_instr  out  WORD_LEN  instruction in IF/ID
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped on zero word
fetch_err  out  1  sticky: misaligned or out-of-range redirect
fetch_count  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (nReset low at posedge clk; synchronous, active-low):
  - pc=RESET_PC, state=BOOT.
  - ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, ifid_valid=0.
  - halted=0, fetch_err=0, fetch_count=0.
  - Reset asserted mid-operation overrides all other inputs.
- imem_addr = pc, combinational. pc is always held in [0, INSTR_MEM_SIZE-4] and word aligned.
- States: BOOT, RUN, HALT, ERR. All register updates below occur on posedge clk.
- BOOT: exactly one cycle, letting memory contents settle. No capture; ifid_valid=0; stall and redirect are ignored. Next state RUN.
- RUN, priority redirect > stall > normal:
  - Redirect with target legal (redirect_pc[1:0]==0 and redirect_pc < INSTR_MEM_SIZE):
    - pc <= redirect_pc.
    - Flush IF/ID: ifid_instr <= NOP_INSTR, ifid_valid <= 0.
    - fetch_count unchanged. Redirect overrides a simultaneous stall.
  - Redirect with target illegal:
    - Enter ERR; fetch_err <= 1; pc holds; IF/ID flushed as above.
  - Stall (no redirect): pc, all ifid_* outputs and fetch_count hold.
  - Normal, imem_instr != 0:
    - ifid_pc <= pc, ifid_pc_plus4 <= (pc+4) mod INSTR_MEM_SIZE.
    - ifid_instr <= imem_instr, ifid_valid <= 1.
    - pc <= (pc+4) mod INSTR_MEM_SIZE; pc wraps to 0 after INSTR_MEM_SIZE-4.
    - fetch_count += 1, wrapping at 2^32.
  - Normal, imem_instr == 0:
    - Enter HALT; halted <= 1; pc holds at the zero word.
    - ifid_instr <= NOP_INSTR, ifid_valid <= 0; count unchanged.
    - Stall in the same cycle wins: no halt.
- HALT:
  - pc and IF/ID held; ifid_valid=0; stall ignored.
  - A legal redirect is a wrong-path cancel: halted <= 0, pc <= redirect_pc, next state RUN.
  - An illegal redirect enters ERR.
- ERR: terminal until reset.
  - fetch_err=1; halted=0; ifid_valid=0; pc held.
  - All inputs except nReset ignored.
- Fetch latency: instruction at pc appears on ifid_* one cycle after pc is presented.
- First valid IF/ID is the 2nd posedge after reset release: BOOT cycle, then capture.

Test Plan:
- Reset, memory holds 4 non-zero words at 0..12, no stall → ifid_valid rises at 2nd post-reset edge; ifid_pc 0,4,8,12 on consecutive cycles; fetch_count=4; word at 16 is 0 → halted=1, pc=16.
- Stall asserted for 3 cycles while ifid_pc=4 → ifid_pc/instr/count frozen 3 cycles; pc stays 8; capture resumes with ifid_pc=8.
- redirect_valid with redirect_pc=0x20 plus stall in the same cycle → next cycle ifid_valid=0, ifid_instr=0x00000013, imem_addr=0x20; following cycle ifid_pc=0x20.
- In HALT at pc=16, redirect_pc=4 → halted=0, RUN, ifid_pc=4 two cycles later.
- redirect_pc=0x22, then separately redirect_pc=0x400 (INSTR_MEM_SIZE=1024) → fetch_err=1, ifid_valid=0, pc held; only nReset clears fetch_err.
- pc=0x3FC, word non-zero → ifid_pc_plus4=0, next imem_addr=0; nReset low mid-run → all outputs at reset values the next edge.
